// File: rtl/commit_watchdog.sv
// Retirement monitor for an RVFI commit port: checks order, PC continuity and x0 writes,
// detects the jump-to-self halt idiom and raises a stall timeout when commits stop.
module commit_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit,
  input  logic [63:0] order,
  input  logic [31:0] pc_rdata,
  input  logic [31:0] pc_wdata,
  input  logic        load_regfile,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_wdata,
  output logic        halt,
  output logic        timeout,
  output logic [7:0]  errcode,
  output logic [63:0] commit_count
);

  typedef enum logic [1:0] {StRun, StHalted, StError} state_e;

  localparam logic [7:0] ErrNone    = 8'd0;
  localparam logic [7:0] ErrOrder   = 8'd1;
  localparam logic [7:0] ErrX0Write = 8'd2;
  localparam logic [7:0] ErrPcJump  = 8'd3;
  localparam logic [7:0] ErrStall   = 8'd4;

  state_e           state_q;
  logic [63:0]      exp_order_q;
  logic [31:0]      prev_pc_wdata_q;
  logic             have_prev_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             halt_q;
  logic             timeout_q;
  logic [7:0]       errcode_q;
  logic [63:0]      commit_count_q;

  logic             order_err;
  logic             x0_err;
  logic             pc_err;
  logic [7:0]       chk_code;
  logic [CNT_W-1:0] stall_cnt_d;

  always_comb begin
    order_err   = (order != exp_order_q);
    x0_err      = load_regfile && (rd_addr == 5'd0) && (rd_wdata != 32'd0);
    pc_err      = have_prev_q && (pc_rdata != prev_pc_wdata_q);
    stall_cnt_d = stall_cnt_q + 1'b1;
    // Lowest failing code wins when several checks trip together.
    if (order_err) begin
      chk_code = ErrOrder;
    end else if (x0_err) begin
      chk_code = ErrX0Write;
    end else if (pc_err) begin
      chk_code = ErrPcJump;
    end else begin
      chk_code = ErrNone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StRun;
      exp_order_q     <= 64'd0;
      prev_pc_wdata_q <= 32'd0;
      have_prev_q     <= 1'b0;
      stall_cnt_q     <= '0;
      halt_q          <= 1'b0;
      timeout_q       <= 1'b0;
      errcode_q       <= ErrNone;
      commit_count_q  <= 64'd0;
    end else begin
      case (state_q)
        StRun: begin
          if (commit) begin
            if (chk_code != ErrNone) begin
              state_q   <= StError;
              errcode_q <= chk_code;
            end else begin
              exp_order_q     <= exp_order_q + 64'd1;
              commit_count_q  <= commit_count_q + 64'd1;
              prev_pc_wdata_q <= pc_wdata;
              have_prev_q     <= 1'b1;
              stall_cnt_q     <= '0;
              if (pc_wdata == pc_rdata) begin
                state_q <= StHalted;
                halt_q  <= 1'b1;
              end
            end
          end else begin
            stall_cnt_q <= stall_cnt_d;
            if (stall_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
              state_q   <= StError;
              timeout_q <= 1'b1;
              errcode_q <= ErrStall;
            end
          end
        end
        // Terminal states: everything holds until reset.
        default: ;
      endcase
    end
  end

  assign halt         = halt_q;
  assign timeout      = timeout_q;
  assign errcode      = errcode_q;
  assign commit_count = commit_count_q;

endmodule

// File: doc/commit_watchdog.md
# commit_watchdog

Synthesizable RTL monitor that sits directly downstream of the CPU's RVFI commit port. It checks every retired instruction for ordering, PC continuity and x0 writes, and detects the halt idiom (a committed jump-to-self). It also flags a stalled core, one that commits nothing for too long. It drives the `halt` and `errcode` fields that the simulation top consumes to end a run.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 1000: consecutive commit-free cycles in RUN before a stall error is raised.
- CNT_W, default 32: width of the stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- commit  in  1  one instruction retires this cycle; all other inputs are valid only when it is high.
- order  in  64  retirement sequence number from the core.
- pc_rdata  in  32  PC of the retiring instruction.
- pc_wdata  in  32  next PC after the retiring instruction.
- load_regfile  in  1  the retiring instruction writes rd.
- rd_addr  in  5  destination register.
- rd_wdata  in  32  value written to rd.
- halt  out  1  registered; program reached a jump-to-self.
- timeout  out  1  registered; stall watchdog fired.
- errcode  out  8  registered, sticky; first error detected.
- commit_count  out  64  registered; number of commits accepted.

## Operation

- States: RUN, HALTED, ERROR. Reset state is RUN.
- Internal registers:
  - exp_order (64b, reset 0)
  - prev_pc_wdata (32b)
  - have_prev (1b, reset 0)
  - stall_cnt (CNT_W, reset 0)
- Checks, evaluated in RUN only when commit=1, all in the same cycle:
  - code 1: order != exp_order.
  - code 2: load_regfile && rd_addr==0 && rd_wdata!=0.
  - code 3: have_prev && pc_rdata != prev_pc_wdata.
  - If several fail, the lowest code is recorded.
- RUN, commit=1 with no check failing:
  - exp_order += 1 (wraps modulo 2^64), commit_count += 1.
  - prev_pc_wdata <= pc_wdata, have_prev <= 1, stall_cnt <= 0.
  - If pc_wdata == pc_rdata, go to HALTED and set halt=1.
- RUN, commit=1 with any check failing:
  - Go to ERROR and latch errcode.
  - halt is not asserted, even if the instruction is a jump-to-self (error wins).
  - commit_count is not incremented.
- RUN, commit=0:
  - stall_cnt += 1.
  - If the incremented value equals TIMEOUT_CYCLES, set timeout=1, errcode=4, go to ERROR.
  - A commit in the cycle the counter would reach the threshold takes precedence: the counter clears and no timeout occurs.
- HALTED and ERROR are terminal until reset:
  - commits are ignored and perform no checks or counting.
  - stall_cnt is frozen.
  - halt, timeout and errcode hold their values.
- errcode encoding: 0 none, 1 order, 2 x0 write, 3 PC discontinuity, 4 stall timeout. Once nonzero it never changes before reset.

## Timing

- Reset values: halt=0, timeout=0, errcode=0, commit_count=0, state RUN.
- Reset is asynchronous and may occur mid-run. All outputs clear immediately on rst_n low, with no clock edge required.
- Latency: every output reflects a commit in cycle N from cycle N+1. All checks are purely combinational on the inputs plus registered state.
- Commits may arrive back to back, one per cycle, with no gaps; throughput is one commit per cycle.
- There is no backpressure; the monitor never stalls the core.
- Timeout first fires exactly TIMEOUT_CYCLES commit-free cycles after reset deassertion or after the last accepted commit, with timeout high from the following edge.

## Test plan

- Reset release, then 4 back-to-back commits: order 0..3, PCs 0x60→0x64→0x68→0x6C→0x70 → commit_count=4, errcode=0, halt=0.
- Commit with pc_rdata=0x80 and pc_wdata=0x80, order matching → halt=1 next cycle. A further commit then leaves commit_count unchanged.
- Commit with order=5 when exp_order=2 → errcode=1 next cycle. A later x0-write violation leaves errcode at 1.
- Single commit that is simultaneously a jump-to-self, writes x0 with 0xDEAD, and has a PC mismatch → errcode=2, halt=0.
- With TIMEOUT_CYCLES=10: no commits for 9 cycles then a commit → no timeout. Then 10 idle cycles → timeout=1 and errcode=4.
- rst_n pulsed low mid-run between clock edges → all outputs 0 immediately. A first commit with arbitrary pc_rdata passes the PC check.
